// File: rtl/uart_prog_loader.sv
// uart_prog_loader: packs UART bytes into little-endian words, writes them to instruction memory
// and holds the CPU in reset until the image is loaded. Optional trailing checksum: LOADER_CHECKSUM_EN.
module uart_prog_loader #(
    parameter int CELL_NUMBERS = 32,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              load_done_o,
    output logic              cpu_rst_o,
    output logic              load_err_o
);

    localparam int                 TIMER_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0]  LAST_WORD = ADDR_W'(CELL_NUMBERS - 1);

    typedef enum logic [2:0] {
        ASSEMBLE,
        WRITE,
`ifdef LOADER_CHECKSUM_EN
        CHECK,
        ERR,
`endif
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0]  word_cnt_q, word_cnt_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [23:0]        word_q, word_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ASSEMBLE;
            byte_cnt_q  <= '0;
            word_cnt_q  <= '0;
            timer_q     <= '0;
            word_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            timer_q     <= timer_d;
            word_q      <= word_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // The 4th byte goes straight into the memory data register, so only lanes 0..2 are buffered.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        timer_d     = timer_q;
        word_d      = word_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        rx_ready_o  = 1'b0;
        mem_we_o    = 1'b0;
        load_done_o = 1'b0;
        cpu_rst_o   = 1'b1;
        load_err_o  = 1'b0;

        case (state_q)
            ASSEMBLE: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    timer_d    = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = csum_q ^ rx_data_i;
`endif
                    case (byte_cnt_q)
                        2'd0: word_d[7:0]   = rx_data_i;
                        2'd1: word_d[15:8]  = rx_data_i;
                        2'd2: word_d[23:16] = rx_data_i;
                        default: begin
                            mem_addr_d  = word_cnt_q;
                            mem_wdata_d = {rx_data_i, word_q};
                            state_d     = WRITE;
                        end
                    endcase
                end else if (byte_cnt_q != 2'd0) begin
                    // A stalled partial word is dropped; earlier whole words stay written.
                    if (timer_q == TIMER_MAX) begin
                        byte_cnt_d = '0;
                        timer_d    = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                mem_we_o   = 1'b1;
                byte_cnt_d = '0;
                timer_d    = '0;
                if (word_cnt_q == LAST_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = DONE;
`endif
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = ASSEMBLE;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                rx_ready_o = 1'b1;
                if (rx_valid_i) begin
                    state_d = (rx_data_i == csum_q) ? DONE : ERR;
                end
            end
            ERR: begin
                load_err_o = 1'b1;
            end
`endif
            DONE: begin
                load_done_o = 1'b1;
                cpu_rst_o   = 1'b0;
            end
            default: begin
                state_d = ASSEMBLE;
            end
        endcase
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed checks of the UART program loader with a 2-word image
// and a 1-word image instance sharing the same byte stream.
module tb_uart_prog_loader;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxValid;
    logic [7:0]  rxData;

    logic        rxReady0, memWe0, loadDone0, cpuRst0, loadErr0;
    logic [7:0]  memAddr0;
    logic [31:0] memWdata0;
    logic        rxReady1, memWe1, loadDone1, cpuRst1, loadErr1;
    logic [7:0]  memAddr1;
    logic [31:0] memWdata1;

    int vectors = 0;
    int miscompares = 0;
    int stalls;
    logic [7:0]  modelCsum;
    logic [7:0]  stream[$];
    logic [7:0]  wa0[$];
    logic [31:0] wd0[$];
    logic [7:0]  wa1[$];
    logic [31:0] wd1[$];
    logic [7:0]  img [8] = '{8'h13, 8'h01, 8'h10, 8'h00, 8'h93, 8'h01, 8'h50, 8'h00};

    uart_prog_loader #(.CELL_NUMBERS(2), .ADDR_W(8), .TIMEOUT_CYC(TO)) dut0 (
        .clk(clk), .rst(rst), .rx_valid_i(rxValid), .rx_data_i(rxData),
        .rx_ready_o(rxReady0), .mem_we_o(memWe0), .mem_addr_o(memAddr0), .mem_wdata_o(memWdata0),
        .load_done_o(loadDone0), .cpu_rst_o(cpuRst0), .load_err_o(loadErr0)
    );

    uart_prog_loader #(.CELL_NUMBERS(1), .ADDR_W(8), .TIMEOUT_CYC(TO)) dut1 (
        .clk(clk), .rst(rst), .rx_valid_i(rxValid), .rx_data_i(rxData),
        .rx_ready_o(rxReady1), .mem_we_o(memWe1), .mem_addr_o(memAddr1), .mem_wdata_o(memWdata1),
        .load_done_o(loadDone1), .cpu_rst_o(cpuRst1), .load_err_o(loadErr1)
    );

    always #5 clk = ~clk;

    // Record every memory write seen by either instance.
    always @(negedge clk) begin
        if (memWe0 === 1'b1) begin
            wa0.push_back(memAddr0);
            wd0.push_back(memWdata0);
        end
        if (memWe1 === 1'b1) begin
            wa1.push_back(memAddr1);
            wd1.push_back(memWdata1);
        end
    end

    task do_reset;
        rst = 1'b1;
        rxValid = 1'b0;
        rxData = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
        modelCsum = 8'h00;
    endtask

    // Sends queued bytes on the 2-word instance's handshake; returns at the negedge after the last transfer.
    task drive_stream;
        int waitN;
        stalls = 0;
        while (stream.size() > 0) begin
            rxData = stream.pop_front();
            rxValid = 1'b1;
            waitN = 0;
            while (rxReady0 !== 1'b1 && waitN < 64) begin
                @(negedge clk);
                waitN++;
                stalls++;
            end
            if (waitN >= 64) begin
                vectors++; miscompares++;
                $display("[TB] FAIL drive_timeout: rx_ready=%b, required 1", rxReady0);
                stream.delete();
            end else begin
                modelCsum = modelCsum ^ rxData;
                @(negedge clk);
            end
        end
        rxValid = 1'b0;
    endtask

    task load_image;
        foreach (img[i]) stream.push_back(img[i]);
    endtask

    task finish_image;
        logic [7:0] c;
        repeat (2) @(negedge clk);
`ifdef LOADER_CHECKSUM_EN
        c = modelCsum;
        stream.push_back(c);
        drive_stream;
`endif
    endtask

    task test_reset;
        rst = 1'b1;
        rxValid = 1'b0;
        rxData = 8'h00;
        @(negedge clk);
        vectors++; if (rxReady0 !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rx_ready: got %b want 1", rxReady0); end
        vectors++; if (memWe0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_we: got %b want 0", memWe0); end
        vectors++; if (memAddr0 !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_mem_addr: got %h want 00", memAddr0); end
        vectors++; if (memWdata0 !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", memWdata0); end
        vectors++; if (loadDone0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_load_done: got %b want 0", loadDone0); end
        vectors++; if (cpuRst0 !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_cpu_rst: got %b want 1", cpuRst0); end
        vectors++; if (loadErr0 !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_load_err: got %b want 0", loadErr0); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (rxReady0 !== 1'b1 || cpuRst0 !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_after_reset: ready=%b cpu_rst=%b want 1 1", rxReady0, cpuRst0); end
    endtask

    task test_back_to_back;
        do_reset;
        load_image;
        drive_stream;
        vectors++; if (stalls !== 1) begin miscompares++; $display("[TB] FAIL b2b_stall_cycles: got %0d want 1", stalls); end
        vectors++; if (memWe0 !== 1'b1 || memAddr0 !== 8'h01 || memWdata0 !== 32'h00500193) begin miscompares++; $display("[TB] FAIL b2b_last_write: we=%b addr=%h data=%h want 1 01 00500193", memWe0, memAddr0, memWdata0); end
        vectors++; if (loadDone0 !== 1'b0 || cpuRst0 !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_done_early: done=%b cpu_rst=%b want 0 1", loadDone0, cpuRst0); end
`ifdef LOADER_CHECKSUM_EN
        finish_image;
`else
        @(negedge clk);
        vectors++; if (loadErr0 !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_load_err: got %b want 0", loadErr0); end
`endif
        vectors++; if (loadDone0 !== 1'b1 || cpuRst0 !== 1'b0 || rxReady0 !== 1'b0 || memWe0 !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_done: done=%b cpu_rst=%b ready=%b we=%b want 1 0 0 0", loadDone0, cpuRst0, rxReady0, memWe0); end
        vectors++; if (wa0.size() !== 2) begin miscompares++; $display("[TB] FAIL b2b_write_count: got %0d want 2", wa0.size()); end
        if (wa0.size() == 2) begin
            vectors++; if (wa0[0] !== 8'h00 || wd0[0] !== 32'h00100113) begin miscompares++; $display("[TB] FAIL b2b_write0: addr=%h data=%h want 00 00100113", wa0[0], wd0[0]); end
            vectors++; if (wa0[1] !== 8'h01 || wd0[1] !== 32'h00500193) begin miscompares++; $display("[TB] FAIL b2b_write1: addr=%h data=%h want 01 00500193", wa0[1], wd0[1]); end
        end
        rxValid = 1'b1;
        rxData = 8'hFF;
        repeat (5) @(negedge clk);
        rxValid = 1'b0;
        @(negedge clk);
        vectors++; if (wa0.size() !== 2 || loadDone0 !== 1'b1) begin miscompares++; $display("[TB] FAIL done_sticky: writes=%0d done=%b want 2 1", wa0.size(), loadDone0); end
        vectors++; if (memAddr0 !== 8'h01 || memWdata0 !== 32'h00500193) begin miscompares++; $display("[TB] FAIL mem_hold: addr=%h data=%h want 01 00500193", memAddr0, memWdata0); end
    endtask

    task test_gapped;
        do_reset;
        foreach (img[i]) begin
            stream.push_back(img[i]);
            drive_stream;
            repeat (3) @(negedge clk);
        end
        finish_image;
        vectors++; if (loadDone0 !== 1'b1 || cpuRst0 !== 1'b0) begin miscompares++; $display("[TB] FAIL gapped_done: done=%b cpu_rst=%b want 1 0", loadDone0, cpuRst0); end
        vectors++; if (wd0.size() !== 2) begin miscompares++; $display("[TB] FAIL gapped_write_count: got %0d want 2", wd0.size()); end
        if (wd0.size() == 2) begin
            vectors++; if (wd0[0] !== 32'h00100113 || wd0[1] !== 32'h00500193) begin miscompares++; $display("[TB] FAIL gapped_data: %h %h want 00100113 00500193", wd0[0], wd0[1]); end
        end
    endtask

    task test_timeout;
        // Idle just short of the limit: the partial word must survive.
        do_reset;
        stream.push_back(8'hAA); stream.push_back(8'hBB);
        drive_stream;
        repeat (TO - 2) @(negedge clk);
        stream.push_back(8'hCC); stream.push_back(8'hDD);
        drive_stream;
        vectors++; if (memWe0 !== 1'b1 || memAddr0 !== 8'h00 || memWdata0 !== 32'hDDCCBBAA) begin miscompares++; $display("[TB] FAIL timeout_short_idle: we=%b addr=%h data=%h want 1 00 DDCCBBAA", memWe0, memAddr0, memWdata0); end

        do_reset;
        stream.push_back(8'hAA); stream.push_back(8'hBB);
        drive_stream;
        repeat (TO) @(negedge clk);
        vectors++; if (wa0.size() !== 0) begin miscompares++; $display("[TB] FAIL timeout_spurious_write: got %0d writes want 0", wa0.size()); end
        load_image;
        drive_stream;
        finish_image;
        vectors++; if (loadDone0 !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_done: got %b want 1", loadDone0); end
        vectors++; if (wa0.size() !== 2) begin miscompares++; $display("[TB] FAIL timeout_write_count: got %0d want 2", wa0.size()); end
        if (wa0.size() == 2) begin
            vectors++; if (wa0[0] !== 8'h00 || wd0[0] !== 32'h00100113) begin miscompares++; $display("[TB] FAIL timeout_write0: addr=%h data=%h want 00 00100113", wa0[0], wd0[0]); end
            vectors++; if (wa0[1] !== 8'h01 || wd0[1] !== 32'h00500193) begin miscompares++; $display("[TB] FAIL timeout_write1: addr=%h data=%h want 01 00500193", wa0[1], wd0[1]); end
        end
    endtask

    task test_reset_midload;
        do_reset;
        for (int i = 0; i < 6; i++) stream.push_back(img[i]);
        drive_stream;
        vectors++; if (wa0.size() !== 1) begin miscompares++; $display("[TB] FAIL midload_first_write: got %0d writes want 1", wa0.size()); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (cpuRst0 !== 1'b1 || memAddr0 !== 8'h00 || memWdata0 !== 32'h0) begin miscompares++; $display("[TB] FAIL midload_reset: cpu_rst=%b addr=%h data=%h want 1 00 0", cpuRst0, memAddr0, memWdata0); end
        do_reset;
        for (int i = 0; i < 7; i++) stream.push_back(img[i]);
        drive_stream;
        vectors++; if (cpuRst0 !== 1'b1 || loadDone0 !== 1'b0) begin miscompares++; $display("[TB] FAIL midload_cpu_rst_held: cpu_rst=%b done=%b want 1 0", cpuRst0, loadDone0); end
        stream.push_back(img[7]);
        drive_stream;
        finish_image;
        vectors++; if (cpuRst0 !== 1'b0 || loadDone0 !== 1'b1) begin miscompares++; $display("[TB] FAIL midload_done: cpu_rst=%b done=%b want 0 1", cpuRst0, loadDone0); end
        vectors++; if (wa0.size() !== 2) begin miscompares++; $display("[TB] FAIL midload_write_count: got %0d want 2", wa0.size()); end
        if (wa0.size() == 2) begin
            vectors++; if (wa0[0] !== 8'h00 || wd0[0] !== 32'h00100113 || wd0[1] !== 32'h00500193) begin miscompares++; $display("[TB] FAIL midload_writes: addr0=%h d0=%h d1=%h want 00 00100113 00500193", wa0[0], wd0[0], wd0[1]); end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task test_checksum;
        logic [7:0] bad;
        do_reset;
        load_image;
        drive_stream;
        repeat (2) @(negedge clk);
        vectors++; if (rxReady0 !== 1'b1 || loadDone0 !== 1'b0) begin miscompares++; $display("[TB] FAIL csum_wait: ready=%b done=%b want 1 0", rxReady0, loadDone0); end
        bad = modelCsum ^ 8'h01;
        stream.push_back(bad);
        drive_stream;
        vectors++; if (loadErr0 !== 1'b1 || cpuRst0 !== 1'b1 || loadDone0 !== 1'b0 || rxReady0 !== 1'b0) begin miscompares++; $display("[TB] FAIL csum_err: err=%b cpu_rst=%b done=%b ready=%b want 1 1 0 0", loadErr0, cpuRst0, loadDone0, rxReady0); end
        rxValid = 1'b1;
        rxData = 8'h00;
        repeat (4) @(negedge clk);
        rxValid = 1'b0;
        vectors++; if (loadErr0 !== 1'b1 || loadDone0 !== 1'b0) begin miscompares++; $display("[TB] FAIL csum_err_sticky: err=%b done=%b want 1 0", loadErr0, loadDone0); end
    endtask
`else
    task test_single_cell;
        do_reset;
        stream.push_back(8'h33); stream.push_back(8'h01); stream.push_back(8'h31); stream.push_back(8'h00);
        drive_stream;
        vectors++; if (memWe1 !== 1'b1 || memAddr1 !== 8'h00 || memWdata1 !== 32'h00310133) begin miscompares++; $display("[TB] FAIL single_write: we=%b addr=%h data=%h want 1 00 00310133", memWe1, memAddr1, memWdata1); end
        @(negedge clk);
        vectors++; if (loadDone1 !== 1'b1 || cpuRst1 !== 1'b0 || rxReady1 !== 1'b0 || loadErr1 !== 1'b0) begin miscompares++; $display("[TB] FAIL single_done: done=%b cpu_rst=%b ready=%b err=%b want 1 0 0 0", loadDone1, cpuRst1, rxReady1, loadErr1); end
        vectors++; if (loadDone0 !== 1'b0) begin miscompares++; $display("[TB] FAIL two_word_not_done: got %b want 0", loadDone0); end
        stream.push_back(8'h33); stream.push_back(8'h01); stream.push_back(8'h31); stream.push_back(8'h00);
        drive_stream;
        @(negedge clk);
        vectors++; if (wa1.size() !== 1 || loadDone0 !== 1'b1) begin miscompares++; $display("[TB] FAIL single_extra_bytes: writes1=%0d done0=%b want 1 1", wa1.size(), loadDone0); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        rxValid = 1'b0;
        rxData = 8'h00;
        modelCsum = 8'h00;
        test_reset;
        test_back_to_back;
        test_gapped;
        test_timeout;
        test_reset_midload;
`ifdef LOADER_CHECKSUM_EN
        test_checksum;
`else
        test_single_cell;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
